part4b3_mac_acc: RTL and testbench

- Signed 14x14 multiply-accumulate unit with a pipelined multiplier and a saturating 28-bit accumulator.
- Each accepted (a, b) pair is multiplied and the product is added into the running sum f.
- valid_out pulses once per accumulated product.
- Used as the compute core in the Part 4 MAC datapath and driven by a streaming source with a per-cycle valid qualifier.

---
 rtl/mac_pkg.sv | 15 +
 rtl/part4b3_mult_pipe.sv | 43 ++++
 rtl/part4b3_mac_acc.sv | 81 ++++++++
 tb/tb_part4b3_mac_acc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths, operand/accumulator types and saturation limits for the
// Part 4 MAC datapath.
package mac_pkg;

    localparam int unsigned A_W         = 14;
    localparam int unsigned F_W         = 2 * A_W;
    localparam int unsigned MULT_STAGES = 3;

    typedef logic signed [A_W-1:0] operand_t;
    typedef logic signed [F_W-1:0] acc_t;

    localparam acc_t ACC_MAX = acc_t'(134217727);
    localparam acc_t ACC_MIN = acc_t'(-134217728);

endpackage : mac_pkg

// File: rtl/part4b3_mult_pipe.sv
// Signed A_W x A_W multiplier followed by STAGES product registers, with a
// valid bit travelling alongside each stage.
module part4b3_mult_pipe
    import mac_pkg::*;
#(
    parameter int unsigned STAGES = MULT_STAGES
) (
    input  logic     clk,
    input  logic     rst_n,
    input  operand_t a_i,
    input  operand_t b_i,
    input  logic     vld_i,
    output acc_t     p_o,
    output logic     vld_o
);

    acc_t              prod_c;
    acc_t              prod_q [STAGES];
    logic [STAGES-1:0] vld_q;

    // Full-width product; the extreme case (-8192)^2 still fits in F_W bits.
    assign prod_c = acc_t'(a_i) * acc_t'(b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= vld_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign p_o   = prod_q[STAGES-1];
    assign vld_o = vld_q[STAGES-1];

endmodule : part4b3_mult_pipe

// File: rtl/part4b3_mac_acc.sv
// Signed multiply-accumulate core: registered inputs, pipelined multiplier and
// a saturating accumulator that updates once per valid product.
module part4b3_mac_acc
    import mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [A_W-1:0] a,
    input  logic signed [A_W-1:0] b,
    input  logic                  valid_in,
    output logic signed [F_W-1:0] f,
    output logic                  valid_out
);

    localparam int unsigned SUM_W = F_W + 1;

    operand_t                 a_q;
    operand_t                 b_q;
    logic                     v0_q;
    acc_t                     prod;
    logic                     prod_vld;
    logic signed [SUM_W-1:0]  sum_c;
    acc_t                     f_d;
    acc_t                     f_q;
    logic                     vout_d;
    logic                     vout_q;

    // Operand capture runs every cycle; the valid bit decides whether it counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v0_q <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            v0_q <= valid_in;
        end
    end

    part4b3_mult_pipe #(
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clk   (clk),
        .rst_n (reset),
        .a_i   (a_q),
        .b_i   (b_q),
        .vld_i (v0_q),
        .p_o   (prod),
        .vld_o (prod_vld)
    );

    // One extra sum bit exposes overflow: the top two bits disagree exactly
    // when the true sum left the accumulator range.
    always_comb begin
        sum_c  = SUM_W'(f_q) + SUM_W'(prod);
        f_d    = f_q;
        vout_d = prod_vld;
        if (prod_vld) begin
            case (sum_c[SUM_W-1 -: 2])
                2'b01:   f_d = ACC_MAX;
                2'b10:   f_d = ACC_MIN;
                default: f_d = sum_c[F_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q    <= '0;
            vout_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            vout_q <= vout_d;
        end
    end

    assign f         = f_q;
    assign valid_out = vout_q;

endmodule : part4b3_mac_acc

// File: tb/tb_part4b3_mac_acc.sv
// Scoreboard bench for part4b3_mac_acc: a saturating reference sum and the
// expected arrival cycle are queued per accepted pair and checked on output.
module tb_part4b3_mac_acc;

    logic                clk;
    logic                reset;
    logic signed [13:0]  a;
    logic signed [13:0]  b;
    logic                valid_in;
    logic signed [27:0]  f;
    logic                valid_out;

    typedef struct {
        longint f;
        int     cyc;
    } exp_t;

    exp_t   sb [$];
    int     cyc;
    int     n_cmp;
    int     n_err;
    longint model_f;
    longint f_hold;
    bit     mon_en;

    part4b3_mac_acc dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .f         (f),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus; accepted pairs update the reference sum.
    task automatic drive(input int ai, input int bi, input bit vi);
        longint s;
        exp_t   e;
        @(negedge clk);
        a        = 14'(ai);
        b        = 14'(bi);
        valid_in = vi;
        if (vi) begin
            s = model_f + longint'(ai) * longint'(bi);
            if (s > 134217727)  s = 134217727;
            if (s < -134217728) s = -134217728;
            model_f = s;
            e.f     = s;
            e.cyc   = cyc + 5;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        model_f  = 0;
        f_hold   = 0;
        #1;
        check_val("rst_f", f, 0);
        check_val("rst_vout", valid_out, 0);
        repeat (2) @(negedge clk);
        check_val("rst_hold_f", f, 0);
        #1 reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check_val("drain", sb.size(), 0);
        @(negedge clk);
        #1;
    endtask

    // Output monitor: a pulse must appear exactly when the front entry is due.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && reset) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check_val("vout", valid_out, 1);
                check_val("f", f, e.f);
                f_hold = e.f;
            end else begin
                check_val("vout_idle", valid_out, 0);
                check_val("f_hold", f, f_hold);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        a        = '0;
        b        = '0;
        valid_in = 1'b0;
        cyc      = 0;
        n_cmp    = 0;
        n_err    = 0;
        model_f  = 0;
        f_hold   = 0;
        mon_en   = 1'b0;

        // Reset then idle with non-zero operands on the bus.
        apply_reset();
        for (int i = 0; i < 10; i++) drive(5, 7, 1'b0);
        check_val("idle_f", f, 0);

        // Single product, latency and hold.
        drive(3, 4, 1'b1);
        idle(8);
        drain();
        check_val("single_hold", f, 12);

        // Signed stream with a one-cycle gap before the last pair.
        apply_reset();
        drive(3, 4, 1'b1);
        drive(-5, 6, 1'b1);
        drive(-7, -2, 1'b1);
        drive(0, 0, 1'b0);
        drive(100, -100, 1'b1);
        idle(2);
        drain();
        check_val("stream_end", f, -10004);

        // Positive saturation and recovery.
        apply_reset();
        for (int i = 0; i < 3; i++) drive(8191, 8191, 1'b1);
        drive(-1, 1, 1'b1);
        idle(2);
        drain();
        check_val("pos_sat_end", f, 134217726);

        // Negative saturation.
        apply_reset();
        for (int i = 0; i < 3; i++) drive(-8192, 8191, 1'b1);
        idle(2);
        drain();
        check_val("neg_sat_end", f, -134217728);

        // Asynchronous reset with products in flight.
        drive(10, 10, 1'b1);
        drive(2, 2, 1'b1);
        drive(0, 0, 1'b0);
        #2;
        reset = 1'b0;
        sb.delete();
        model_f = 0;
        f_hold  = 0;
        #1;
        check_val("async_rst_f", f, 0);
        check_val("async_rst_vout", valid_out, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        idle(8);
        drive(1, 1, 1'b1);
        idle(2);
        drain();
        check_val("post_rst_f", f, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_part4b3_mac_acc
